joystick_dir_decoder: RTL and testbench

Downstream consumer of the MCP3008 dual-channel SPI driver. It paces conversions by pulsing the driver's `start`, captures each X/Y 10-bit sample pair, and calibrates the joystick centre from the first samples after reset. Each deflection is classified into one of four directions with a deadzone and hysteresis, debounced over consecutive samples, and emitted as key-style events with auto-repeat for the LCD menu logic.

---
 rtl/joystick_dir_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_joystick_dir_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/joystick_dir_decoder.sv
// Joystick direction decoder: paces MCP3008 conversions, calibrates the stick
// centre, classifies deflections into four directions with deadzone and
// hysteresis, debounces them and emits key-style events with auto-repeat.
//
// Handshake: the driver owns x_data/y_data; data_valid is a one-cycle strobe
// that qualifies them in that cycle and is never back-pressured. adc_start is
// a one-cycle request; at most one request is outstanding (busy) and pacer
// ticks that land while busy are dropped rather than queued.
module joystick_dir_decoder #(
  parameter int SAMPLE_DIV   = 500000,
  parameter int CAL_SHIFT    = 3,
  parameter int DEADZONE     = 150,
  parameter int HYST         = 20,
  parameter int STABLE_CNT   = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       adc_start,
  input  logic [9:0] x_data,
  input  logic [9:0] y_data,
  input  logic       data_valid,
  input  logic       recal,
  output logic       calibrated,
  output logic [2:0] dir,
  output logic       event_valid,
  output logic [2:0] event_dir,
  output logic       event_repeat
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = 10 + CAL_SHIFT;
  localparam int CW = CAL_SHIFT + 1;
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_RATE + 1);

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic {S_CAL = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          busy_q;
  logic [9:0]    cx_q, cy_q;
  logic [AW-1:0] sx_q, sy_q, sx_sum, sy_sum;
  logic [CW-1:0] cal_cnt_q;
  logic          cal_last;
  logic [2:0]    prev_cand_q, cand;
  logic [SW-1:0] stab_q, stab_n;
  logic [2:0]    dir_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [RW-1:0] rate_q, rate_n;
  logic          rep_fire;
  logic signed [10:0] dx, dy;
  logic [10:0]   ax, ay, m, thr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_CAL;
    else        state_q <= state_d;
  end

  // FSM next state: recal always returns to calibration
  always_comb begin
    state_d = state_q;
    if (recal) state_d = S_CAL;
    else if (data_valid && state_q == S_CAL && cal_last) state_d = S_RUN;
  end

  // Pacer: free-running timer, one outstanding conversion at a time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= '0;
      adc_start <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      if (timer_q == TW'(SAMPLE_DIV - 1)) timer_q <= '0;
      else                                timer_q <= timer_q + TW'(1);
      if (timer_q == TW'(SAMPLE_DIV - 1) && !busy_q) begin
        adc_start <= 1'b1;
        busy_q    <= 1'b1;
      end else if (data_valid) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Calibration sums and the sample that completes the average
  always_comb begin
    sx_sum   = sx_q + AW'(x_data);
    sy_sum   = sy_q + AW'(y_data);
    cal_last = (cal_cnt_q == CW'((1 << CAL_SHIFT) - 1));
  end

  // Classification: dominant axis wins, ties go horizontal; +y is up
  always_comb begin
    dx  = $signed({1'b0, x_data}) - $signed({1'b0, cx_q});
    dy  = $signed({1'b0, y_data}) - $signed({1'b0, cy_q});
    ax  = dx[10] ? 11'(-dx) : 11'(dx);
    ay  = dy[10] ? 11'(-dy) : 11'(dy);
    m   = (ax >= ay) ? ax : ay;
    thr = (dir == DIR_NONE) ? 11'(DEADZONE) : 11'(DEADZONE - HYST);
    cand = DIR_NONE;
    if (m > thr) begin
      if (ax >= ay) cand = (dx > 0) ? DIR_RIGHT : DIR_LEFT;
      else          cand = (dy > 0) ? DIR_UP : DIR_DOWN;
    end
  end

  // Debounce and auto-repeat bookkeeping for the current sample
  always_comb begin
    if (cand == prev_cand_q)
      stab_n = (stab_q == SW'(STABLE_CNT)) ? stab_q : stab_q + SW'(1);
    else
      stab_n = SW'(1);
    dir_n = dir;
    if (stab_n >= SW'(STABLE_CNT) && cand != dir) dir_n = cand;

    hold_n   = '0;
    rate_n   = '0;
    rep_fire = 1'b0;
    if (dir_n == dir && dir != DIR_NONE) begin
      if (hold_q < HW'(REPEAT_DELAY)) begin
        hold_n   = hold_q + HW'(1);
        rep_fire = (hold_n == HW'(REPEAT_DELAY));
      end else begin
        hold_n = hold_q;
        rate_n = rate_q + RW'(1);
        if (rate_n == RW'(REPEAT_RATE)) begin
          rep_fire = 1'b1;
          rate_n   = '0;
        end
      end
    end
  end

  // Sample datapath: calibration accumulate, then direction and events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx_q         <= 10'd512;
      cy_q         <= 10'd512;
      sx_q         <= '0;
      sy_q         <= '0;
      cal_cnt_q    <= '0;
      calibrated   <= 1'b0;
      prev_cand_q  <= DIR_NONE;
      stab_q       <= '0;
      dir          <= DIR_NONE;
      hold_q       <= '0;
      rate_q       <= '0;
      event_valid  <= 1'b0;
      event_dir    <= DIR_NONE;
      event_repeat <= 1'b0;
    end else begin
      event_valid <= 1'b0;
      if (recal) begin
        sx_q        <= '0;
        sy_q        <= '0;
        cal_cnt_q   <= '0;
        calibrated  <= 1'b0;
        prev_cand_q <= DIR_NONE;
        stab_q      <= '0;
        dir         <= DIR_NONE;
        hold_q      <= '0;
        rate_q      <= '0;
      end else if (data_valid) begin
        if (state_q == S_CAL) begin
          sx_q      <= sx_sum;
          sy_q      <= sy_sum;
          cal_cnt_q <= cal_cnt_q + CW'(1);
          if (cal_last) begin
            cx_q       <= sx_sum[AW-1:CAL_SHIFT];
            cy_q       <= sy_sum[AW-1:CAL_SHIFT];
            calibrated <= 1'b1;
          end
        end else begin
          prev_cand_q <= cand;
          stab_q      <= stab_n;
          dir         <= dir_n;
          hold_q      <= hold_n;
          rate_q      <= rate_n;
          if (dir_n != dir && dir_n != DIR_NONE) begin
            event_valid  <= 1'b1;
            event_dir    <= dir_n;
            event_repeat <= 1'b0;
          end else if (rep_fire) begin
            event_valid  <= 1'b1;
            event_dir    <= dir;
            event_repeat <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_joystick_dir_decoder.sv
// Directed bench for joystick_dir_decoder with a 4-cycle driver model and an
// event scoreboard fed by the stimulus steps.
module tb_joystick_dir_decoder;

  logic       clk, rst_n;
  logic       adc_start;
  logic [9:0] x_data, y_data;
  logic       data_valid, recal;
  logic       calibrated;
  logic [2:0] dir;
  logic       event_valid;
  logic [2:0] event_dir;
  logic       event_repeat;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int first_start = -1;
  int last_start = 0;
  int prev_start = 0;
  int extra_starts = 0;
  logic [3:0] exp_q[$];

  joystick_dir_decoder #(
    .SAMPLE_DIV(16), .CAL_SHIFT(3), .DEADZONE(150), .HYST(20),
    .STABLE_CNT(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_start(adc_start),
    .x_data(x_data), .y_data(y_data), .data_valid(data_valid),
    .recal(recal), .calibrated(calibrated), .dir(dir),
    .event_valid(event_valid), .event_dir(event_dir),
    .event_repeat(event_repeat)
  );

  // Clock and cycle counter since reset release
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every event must match the oldest expected {dir, repeat}
  always @(negedge clk) begin
    if (rst_n && event_valid) begin
      check("event_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("event", {event_dir, event_repeat}, exp_q.pop_front());
    end
  end

  // Driver: wait for a request, answer after `delay` cycles
  task automatic sample(input int x, input int y, input int delay, input bit with_recal);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!adc_start && k < 64);
    if (!adc_start) begin
      check("adc_start_timeout", 0, 1);
      return;
    end
    prev_start = last_start;
    last_start = cyc;
    if (first_start < 0) first_start = cyc;
    extra_starts = 0;
    repeat (delay - 1) begin
      @(negedge clk);
      if (adc_start) extra_starts++;
    end
    x_data = 10'(x);
    y_data = 10'(y);
    data_valid = 1'b1;
    recal = with_recal;
    @(negedge clk);
    data_valid = 1'b0;
    recal = 1'b0;
  endtask

  task automatic run(input int x, input int y, input int n, input int exp_dir, input string tag);
    for (int i = 0; i < n; i++) sample(x, y, 4, 1'b0);
    check(tag, 32'(dir), 32'(exp_dir));
  endtask

  initial begin
    rst_n = 1'b0; data_valid = 1'b0; recal = 1'b0;
    x_data = 10'd512; y_data = 10'd512;
    repeat (3) @(negedge clk);
    check("rst_adc_start", 32'(adc_start), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_event_valid", 32'(event_valid), 0);
    check("rst_event_dir", 32'(event_dir), 0);
    check("rst_event_repeat", 32'(event_repeat), 0);
    check("rst_calibrated", 32'(calibrated), 0);
    rst_n = 1'b1;

    // Pacing and calibration from alternating samples: centre 505/525
    for (int i = 0; i < 8; i++) begin
      if (i[0]) sample(510, 530, 4, 1'b0);
      else      sample(500, 520, 4, 1'b0);
      if (i == 6) check("cal_not_yet", 32'(calibrated), 0);
    end
    check("first_start_cycle", 32'(first_start), 16);
    check("cal_done", 32'(calibrated), 1);
    check("cal_no_dir", 32'(dir), 0);
    run(655, 525, 3, 0, "cx_edge_none");
    exp_q.push_back({3'd4, 1'b0});
    run(656, 525, 3, 4, "cx_edge_right");
    exp_q.push_back({3'd1, 1'b0});
    run(505, 676, 3, 1, "cy_edge_up");
    run(505, 525, 3, 0, "release_after_cy");

    // Recalibrate at 512/512
    sample(512, 512, 4, 1'b1);
    check("recal_clears_cal", 32'(calibrated), 0);
    run(512, 512, 8, 0, "recal512_dir");
    check("recal512_cal", 32'(calibrated), 1);

    // Press right with debounce, then a two-sample glitch
    run(700, 512, 2, 0, "debounce_two");
    exp_q.push_back({3'd4, 1'b0});
    run(700, 512, 1, 4, "press_right");
    run(512, 512, 3, 0, "release_right");
    run(700, 512, 2, 0, "glitch_two");
    run(512, 512, 3, 0, "glitch_release");

    // Hysteresis: 140 holds, 125 releases
    exp_q.push_back({3'd4, 1'b0});
    run(700, 512, 3, 4, "hyst_press");
    run(652, 512, 2, 4, "hyst_hold_140");
    run(637, 512, 2, 4, "hyst_125_pending");
    run(637, 512, 1, 0, "hyst_release_125");

    // Auto-repeat on up: repeats at hold counts 5,7,9,11 and 13
    exp_q.push_back({3'd1, 1'b0});
    run(512, 900, 3, 1, "press_up");
    for (int i = 1; i <= 12; i++) begin
      if (i == 5 || i == 7 || i == 9 || i == 11) exp_q.push_back({3'd1, 1'b1});
      sample(512, 900, 4, 1'b0);
    end
    check("hold_up", 32'(dir), 1);
    exp_q.push_back({3'd1, 1'b1});
    run(512, 512, 3, 0, "release_up");

    // Tie goes horizontal; negative dy is down; direct change re-presses
    exp_q.push_back({3'd3, 1'b0});
    run(312, 712, 3, 3, "tie_left");
    exp_q.push_back({3'd2, 1'b0});
    run(512, 212, 3, 2, "left_to_down");
    run(512, 512, 3, 0, "release_down");

    // Slow driver: in-flight ticks are dropped, not queued
    sample(512, 512, 40, 1'b0);
    check("busy_no_extra_start", 32'(extra_starts), 0);
    sample(512, 512, 4, 1'b0);
    check("busy_next_tick", 32'(last_start - prev_start), 48);

    // recal coinciding with a sample: sample discarded, no event
    exp_q.push_back({3'd4, 1'b0});
    run(700, 512, 3, 4, "press_before_recal");
    sample(700, 512, 4, 1'b1);
    check("recal_dir", 32'(dir), 0);
    check("recal_cal", 32'(calibrated), 0);
    run(600, 600, 7, 0, "recal_cal7_dir");
    check("recal_discarded", 32'(calibrated), 0);
    run(600, 600, 1, 0, "recal_cal8_dir");
    check("recal_cal8", 32'(calibrated), 1);
    exp_q.push_back({3'd4, 1'b0});
    run(751, 600, 3, 4, "new_centre_right");

    repeat (4) @(negedge clk);
    check("events_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
